node_mul_seq: RTL and testbench

- Downstream consumer stage for the tree-parser leaf/projection nodes.
- Triggers two child nodes through a shared start line, waits until both report ready, and latches their 16-bit results.
- Computes their product modulo 2^W with a sequential shift-add multiplier, then presents the result with the same ST/RD/RES protocol that the leaf nodes use.
- Allows it to be nested as a child of further operator nodes.

---
 rtl/node_mul_seq.sv | 132 +++++++++++++
 tb/tb_node_mul_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/node_mul_seq.sv
// Operator node: kicks two child nodes, latches their results and multiplies them (mod 2^W) with a
// shift-add loop; start to RD is 1 + WAIT + W + 1 edges, and a new ST rising edge aborts and restarts.
module node_mul_seq #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         ST,
  output logic         RD,
  output logic [W-1:0] RES,
  output logic         CST,
  input  logic         CRD0,
  input  logic         CRD1,
  input  logic [W-1:0] IN0,
  input  logic [W-1:0] IN1
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KICK,
    S_WAIT,
    S_MUL,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          st_old;
  logic          start;
  logic          wait_armed;
  logic [W-1:0]  acc;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [CW-1:0] cnt;

  logic          cst_nxt;
  logic          rd_nxt;
  logic          res_ld;
  logic          op_ld;
  logic          mul_step;

  assign start = ST & ~st_old;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      st_old     <= 1'b0;
      wait_armed <= 1'b0;
      CST        <= 1'b0;
      RD         <= 1'b1;
    end else begin
      state      <= state_nxt;
      st_old     <= ST;
      // Children still report ready from their previous run during the first WAIT cycle.
      wait_armed <= (state == S_WAIT) && (state_nxt == S_WAIT);
      CST        <= cst_nxt;
      RD         <= rd_nxt;
    end
  end

  // A start event from any state wins over everything but reset, including completion in DONE.
  always_comb begin
    state_nxt = state;
    cst_nxt   = 1'b0;
    rd_nxt    = RD;
    res_ld    = 1'b0;
    op_ld     = 1'b0;
    mul_step  = 1'b0;
    if (start) begin
      state_nxt = S_KICK;
      cst_nxt   = 1'b1;
      rd_nxt    = 1'b0;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_IDLE;
        S_KICK: state_nxt = S_WAIT;
        S_WAIT: begin
          if (wait_armed && CRD0 && CRD1) begin
            op_ld     = 1'b1;
            state_nxt = S_MUL;
          end
        end
        S_MUL: begin
          mul_step = 1'b1;
          if (cnt == CNT_LAST) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          res_ld    = 1'b1;
          rd_nxt    = 1'b1;
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Fixed W-step loop with no early exit so latency never depends on the operands.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (op_ld) begin
      acc    <= '0;
      mcand  <= IN0;
      mplier <= IN1;
      cnt    <= '0;
    end else if (mul_step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RES <= '0;
    end else if (res_ld) begin
      RES <= acc;
    end
  end

endmodule

// File: tb/tb_node_mul_seq.sv
// Directed bench for node_mul_seq: two leaf-like child models answer CST after a set number of edges.
module tb_node_mul_seq;

  logic        clk;
  logic        rst;
  logic        st;
  logic        rd;
  logic [15:0] res;
  logic        cst;
  logic        crd0;
  logic        crd1;
  logic [15:0] in0;
  logic [15:0] in1;

  int n_tests = 0;
  int n_fail  = 0;
  int lat0    = 2;
  int lat1    = 2;
  int c0      = 0;
  int c1      = 0;
  logic [15:0] last_res;

  node_mul_seq #(.W(16)) dut (
    .CLK (clk),
    .RST (rst),
    .ST  (st),
    .RD  (rd),
    .RES (res),
    .CST (cst),
    .CRD0(crd0),
    .CRD1(crd1),
    .IN0 (in0),
    .IN1 (in1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Child models: drop ready when CST is seen, raise it lat edges after the edge that samples CST.
  always @(negedge clk) begin
    if (cst) begin
      crd0 = 1'b0;
      c0   = lat0 + 1;
    end else if (c0 > 0) begin
      c0 = c0 - 1;
      if (c0 == 0) crd0 = 1'b1;
    end
    if (cst) begin
      crd1 = 1'b0;
      c1   = lat1 + 1;
    end else if (c1 > 0) begin
      c1 = c1 - 1;
      if (c1 == 0) crd1 = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge right after the start edge; returns edges until RD is seen high.
  task automatic wait_rd(input logic [15:0] res_hold, output int edges, output int cst_cnt,
                         output int res_chg);
    bit done;
    done    = 1'b0;
    edges   = 0;
    cst_cnt = 0;
    res_chg = 0;
    while (!done && edges < 200) begin
      if (cst) cst_cnt++;
      if (rd) begin
        done = 1'b1;
      end else begin
        if (res !== res_hold) res_chg++;
        @(negedge clk);
        edges++;
      end
    end
  endtask

  task automatic pulse_st();
    @(negedge clk);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int slow1, input logic [15:0] exp_res, input int exp_lat);
    int edges, cst_cnt, res_chg;
    in0  = a;
    in1  = b;
    lat1 = slow1;
    pulse_st();
    wait_rd(last_res, edges, cst_cnt, res_chg);
    check({tag, "_lat"}, edges, exp_lat);
    check({tag, "_cst"}, cst_cnt, 1);
    check({tag, "_hold"}, res_chg, 0);
    check({tag, "_res"}, {16'd0, res}, {16'd0, exp_res});
    last_res = exp_res;
  endtask

  initial begin
    int edges, cst_cnt, res_chg, rd_bad;
    rst  = 1'b0;
    st   = 1'b0;
    crd0 = 1'b1;
    crd1 = 1'b1;
    in0  = '0;
    in1  = '0;
    last_res = 16'd0;

    repeat (3) @(negedge clk);
    check("rst_rd", rd, 1);
    check("rst_res", res, 0);
    check("rst_cst", cst, 0);
    rst = 1'b1;
    cst_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (cst) cst_cnt++;
    end
    check("post_rst_cst", cst_cnt, 0);
    check("post_rst_rd", rd, 1);
    check("post_rst_res", res, 0);

    run_op("basic", 16'd3, 16'd7, 2, 16'd21, 21);
    run_op("wrap", 16'h0100, 16'h0101, 2, 16'h0100, 21);
    run_op("zero", 16'h0000, 16'hFFFF, 2, 16'h0000, 21);
    run_op("slow", 16'd5, 16'd9, 12, 16'd45, 31);
    lat1 = 2;

    // Level-high ST must produce exactly one start.
    in0 = 16'd2;
    in1 = 16'd3;
    @(negedge clk);
    st = 1'b1;
    cst_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (cst) cst_cnt++;
    end
    st = 1'b0;
    check("held_cst", cst_cnt, 1);
    check("held_rd", rd, 1);
    check("held_res", res, 6);
    last_res = 16'd6;

    // Restart during MUL: new operands, old RES kept until the new DONE.
    in0 = 16'd4;
    in1 = 16'd5;
    pulse_st();
    cst_cnt = 0;
    rd_bad  = 0;
    repeat (8) begin
      if (cst) cst_cnt++;
      if (rd) rd_bad++;
      @(negedge clk);
    end
    check("rs_first_cst", cst_cnt, 1);
    check("rs_first_rd", rd_bad, 0);
    in0 = 16'd10;
    in1 = 16'd11;
    pulse_st();
    wait_rd(last_res, edges, cst_cnt, res_chg);
    check("rs_lat", edges, 21);
    check("rs_cst", cst_cnt, 1);
    check("rs_hold", res_chg, 0);
    check("rs_res", res, 110);
    last_res = 16'd110;

    // Asynchronous reset between edges while multiplying.
    in0 = 16'd7;
    in1 = 16'd7;
    pulse_st();
    repeat (8) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_rd", rd, 1);
    check("arst_res", res, 0);
    check("arst_cst", cst, 0);
    @(negedge clk);
    rst = 1'b1;
    last_res = 16'd0;
    run_op("after_rst", 16'd3, 16'd5, 2, 16'd15, 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
